// File: rtl/uart_echo_fifo.sv
// UART echo engine: synchronised RX with parity/frame checking, a FIFO of good
// bytes, and a TX that retransmits them in the same configurable frame format.
module uart_echo_fifo #(
    parameter int SYS_PERIOD = 100_000_000,
    parameter int BPS        = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             uart_rxd,
    input  logic                             echo_en,
    output logic                             uart_txd,
    output logic                             tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             rx_parity_err,
    output logic                             rx_frame_err,
    output logic                             fifo_overflow
);
    localparam int  BIT_PERIOD      = SYS_PERIOD / BPS;
    localparam int  HALF_BIT_PERIOD = BIT_PERIOD / 2;
    localparam int  STOP_PERIOD     = STOP_BITS * BIT_PERIOD;
    localparam int  RX_CW           = $clog2(BIT_PERIOD);
    localparam int  TX_CW           = $clog2(STOP_PERIOD);
    localparam int  BIT_W           = $clog2(DATA_BITS);
    localparam int  PTR_W           = $clog2(FIFO_DEPTH);
    localparam int  LVL_W           = $clog2(FIFO_DEPTH + 1);
    localparam bit  HAS_PARITY      = (PARITY != 0);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : ^d;
    endfunction

    // ---------------- RX synchroniser and edge detect ----------------
    logic rx_meta, rx_sync, rx_prev;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state, rx_next;
    logic [RX_CW-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_tick, rx_done, rx_par_bad, rx_good;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        rx_next = rx_state;
        rx_tick = 1'b0;
        rx_done = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: begin
                rx_tick = (rx_cnt == RX_CW'(HALF_BIT_PERIOD - 1));
                if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                rx_tick = (rx_cnt == RX_CW'(BIT_PERIOD - 1));
                if (rx_tick && rx_bit == BIT_W'(DATA_BITS - 1))
                    rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                rx_tick = (rx_cnt == RX_CW'(BIT_PERIOD - 1));
                if (rx_tick) rx_next = RX_STOP;
            end
            RX_STOP: begin
                rx_tick = (rx_cnt == RX_CW'(BIT_PERIOD - 1));
                rx_done = rx_tick;
                if (rx_tick) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_next != rx_state || rx_tick) rx_cnt <= '0;
            else if (rx_state != RX_IDLE)       rx_cnt <= rx_cnt + RX_CW'(1);
            if (rx_next != rx_state)               rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_tick) rx_bit <= rx_bit + BIT_W'(1);
            if (rx_state == RX_DATA && rx_tick)   rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_state == RX_PARITY && rx_tick) rx_par_bit <= rx_sync;
        end
    end

    always_comb begin
        rx_par_bad = 1'b0;
        if (HAS_PARITY) rx_par_bad = (parity_of(rx_shift) != rx_par_bit);
    end

    // A byte is good only if the first stop bit reads 1 and parity (if any) holds.
    assign rx_good = rx_done && rx_sync && !rx_par_bad;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 fifo_full, push, pop;
    tx_state_t            tx_state, tx_next;

    assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop       = (tx_state == TX_IDLE) && (fifo_level != '0) && echo_en;
    assign push      = rx_good && (!fifo_full || pop);

    // NOTE: the storage array is deliberately not reset; pointers and level
    // alone define which entries are valid, and a reset memory costs muxes.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            rx_parity_err <= rx_done && rx_par_bad;
            rx_frame_err  <= rx_done && !rx_sync;
            fifo_overflow <= rx_good && fifo_full && !pop;
        end
    end

    // ---------------- TX FSM ----------------
    logic [TX_CW-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_tick, txd_next;

    always_comb begin
        tx_next  = tx_state;
        tx_tick  = 1'b0;
        txd_next = uart_txd;
        case (tx_state)
            TX_IDLE: if (pop) begin
                tx_next  = TX_START;
                txd_next = 1'b0;
            end
            TX_START: begin
                tx_tick = (tx_cnt == TX_CW'(BIT_PERIOD - 1));
                if (tx_tick) begin
                    tx_next  = TX_DATA;
                    txd_next = tx_shift[0];
                end
            end
            TX_DATA: begin
                tx_tick = (tx_cnt == TX_CW'(BIT_PERIOD - 1));
                if (tx_tick && tx_bit == BIT_W'(DATA_BITS - 1)) begin
                    tx_next  = HAS_PARITY ? TX_PARITY : TX_STOP;
                    txd_next = HAS_PARITY ? tx_par : 1'b1;
                end else if (tx_tick) begin
                    txd_next = tx_shift[1];
                end
            end
            TX_PARITY: begin
                tx_tick = (tx_cnt == TX_CW'(BIT_PERIOD - 1));
                if (tx_tick) begin
                    tx_next  = TX_STOP;
                    txd_next = 1'b1;
                end
            end
            TX_STOP: begin
                tx_tick = (tx_cnt == TX_CW'(STOP_PERIOD - 1));
                if (tx_tick) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_next;
            uart_txd <= txd_next;
            if (tx_next != tx_state || tx_tick) tx_cnt <= '0;
            else if (tx_state != TX_IDLE)       tx_cnt <= tx_cnt + TX_CW'(1);
            if (tx_next != tx_state)                 tx_bit <= '0;
            else if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + BIT_W'(1);
            // shift[0] always holds the bit currently on the line once in DATA
            if (pop) begin
                tx_shift <= mem[rd_ptr];
                tx_par   <= parity_of(mem[rd_ptr]);
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    assign tx_busy = (tx_state != TX_IDLE);

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised UART echo engine, the next generation of our fixed 8N1 receiver-to-transmitter loopback top. It receives frames on uart_rxd with configurable data bits, parity and stop bits, and buffers good bytes in an internal FIFO. It retransmits the bytes on uart_txd in the same frame format. It adds error detection, overflow reporting and an echo gate, and is a self-contained single module.

Parameters:
SYS_PERIOD, 100_000_000, system clock frequency in Hz
BPS, 115_200, baud rate; BIT_PERIOD = SYS_PERIOD/BPS (868 at defaults), HALF_BIT_PERIOD = BIT_PERIOD/2 (434)
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
uart_rxd  input  1  serial in, asynchronous, idle high
echo_en  input  1  1 = TX may pop the FIFO; 0 = hold bytes in the FIFO
uart_txd  output  1  serial out, idle high
tx_busy  output  1  high while the TX state is not IDLE
fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
rx_parity_err  output  1  one-cycle pulse on a parity mismatch
rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled 0
fifo_overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full

Behaviour:
- Reset (rst_n low at a clk edge): uart_txd=1, tx_busy=0, fifo_level=0, all pulses 0, RX and TX FSMs in IDLE, FIFO pointers 0, synchroniser flops set to 1. Reset aborts any frame in progress; uart_txd is 1 from the next edge.
- RX synchroniser: 2 flops; all RX logic uses the synchronised line only.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised 1->0 transition.
  - START: count HALF_BIT_PERIOD cycles, then sample. If the sample is 1 it is a false start: return to IDLE with no flags. Otherwise go to DATA.
  - DATA: sample every BIT_PERIOD cycles, LSB first, DATA_BITS samples. Then go to PARITY if PARITY != 0, else to STOP.
  - PARITY: one sample. Odd parity requires XOR(data, parity bit) = 1; even parity requires 0.
  - STOP: sample the first stop bit only, then go to IDLE on the next cycle. A second stop bit is not checked on RX.
- Stop-sample cycle (S): rx_frame_err pulses at S+1 if the stop bit is 0. rx_parity_err pulses at S+1 on a mismatch. Both may pulse in the same cycle. On either error the byte is discarded.
- Good byte: written to the FIFO at S+1. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and fifo_overflow pulses at S+1.
- Push and pop in the same cycle are both honoured and fifo_level is unchanged. A push while full is accepted if a pop occurs in the same cycle. FIFO order is strictly first-in, first-out.
- fifo_level is registered and updates on the edge where the push or pop takes effect.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE pops when fifo_level != 0 and echo_en = 1. It loads the shift register and goes to START on the same edge; tx_busy rises on that edge.
  - START: uart_txd=0 for BIT_PERIOD cycles.
  - DATA: DATA_BITS bits, LSB first, BIT_PERIOD cycles each.
  - PARITY: present only if PARITY != 0; parity computed per PARITY; BIT_PERIOD cycles.
  - STOP: uart_txd=1 for STOP_BITS*BIT_PERIOD cycles, then IDLE.
- Back-to-back frames have exactly 1 extra idle clock after the stop bits (the IDLE pop cycle).
- Deasserting echo_en never truncates a frame already in progress; it only blocks the next pop.
- uart_txd is driven directly from a register, so there are no glitches.
- Bit counters and baud counters are sized as $clog2 of their maxima. Every counter reloads at each state change; none free-runs.

Test Plan:
- Defaults, drive 0x55 in 8N1 at 868 cycles/bit -> uart_txd falls within 4 clocks of the RX stop sample and echoes 0x55 8N1, each bit 868±0 cycles; no error pulses.
- PARITY=2, drive 0xA3 with parity bit 1 (correct value is 0) -> rx_parity_err pulses exactly 1 cycle; fifo_level stays 0; uart_txd stays 1.
- Defaults, drive 0x3C with the stop bit held 0 -> rx_frame_err pulses 1 cycle; no echo. A following good 0x3C is echoed normally.
- echo_en=0, FIFO_DEPTH=16, drive 18 bytes 0x00..0x11 -> fifo_level=16, fifo_overflow pulses twice (on bytes 0x10 and 0x11). Then set echo_en=1 -> 0x00..0x0F echoed in order, with a 1-clock gap beyond the stop bit between frames, and fifo_level reaches 0.
- Low glitch of 100 cycles on uart_rxd -> no FIFO write and no flags; the RX FSM is back in IDLE.
- DATA_BITS=7, PARITY=1, STOP_BITS=2: echo 0x41 -> frame is 11 bits (start, 7 data, parity, 2 stop) = 9548 cycles with parity bit 1. Assert rst_n=0 mid-frame -> uart_txd=1, tx_busy=0, fifo_level=0 after the next edge.
